// File: rtl/vram_pkg.sv
// vram_pkg: shared constants, CPU FSM states and request/tag types for the VRAM arbiter
package vram_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int DEPTH = 7168;
  localparam int MAX_WAIT = 64;
  localparam int WAIT_W = 7;
  typedef enum logic [1:0] {IDLE, S1, S2, ACK} cpu_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic we;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
  // zero: CPU ack must return 0 data (write or out-of-range access)
  typedef struct packed {
    logic vid;
    logic cpu;
    logic zero;
    logic err;
  } tag_t;
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(DEPTH);
  endfunction
endpackage

// File: rtl/vram_pipe.sv
// vram_pipe: two-stage tag delay line aligning issue tags with RAM read data
module vram_pipe
  import vram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t stage;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stage <= '0;
      tag_out <= '0;
    end else begin
      stage <= tag_in;
      tag_out <= stage;
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM sharing, scanout has absolute priority, CPU served in idle slots
module vram_arbiter
  import vram_pkg::*;
(
  input  logic              CLK_25MHZ,
  input  logic              RESET,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic              VID_VALID,
  output logic [DATA_W-1:0] VID_DATA,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_ERR,
  output logic              CPU_STARVED,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);
  cpu_state_t state, state_nxt;
  mem_req_t mem_q, mem_d;
  tag_t issue_tag, ret_tag;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic cpu_issue, blocked, in_range;
  always_comb begin
    in_range = addr_ok(CPU_ADDR);
    cpu_issue = state == IDLE && CPU_REQ && !VID_REQ;
    blocked = state == IDLE && CPU_REQ && VID_REQ;
    state_nxt = state == IDLE ? (cpu_issue ? S1 : IDLE) :
                state == S1 ? S2 :
                state == S2 ? ACK : IDLE;
    mem_d = VID_REQ ? mem_req_t'{addr: VID_ADDR, we: 1'b0, wdata: mem_q.wdata} :
            cpu_issue ? mem_req_t'{addr: CPU_ADDR, we: CPU_WE && in_range, wdata: CPU_WDATA} :
            mem_req_t'{addr: mem_q.addr, we: 1'b0, wdata: mem_q.wdata};
    issue_tag = tag_t'{vid: VID_REQ, cpu: cpu_issue,
                       zero: cpu_issue && (CPU_WE || !in_range), err: cpu_issue && !in_range};
    wait_nxt = cpu_issue ? '0 :
               (blocked && wait_cnt != WAIT_W'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
  end
  always_ff @(posedge CLK_25MHZ or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      mem_q <= '0;
      wait_cnt <= '0;
      CPU_STARVED <= 1'b0;
    end else begin
      state <= state_nxt;
      mem_q <= mem_d;
      wait_cnt <= wait_nxt;
      CPU_STARVED <= CPU_STARVED || wait_nxt == WAIT_W'(MAX_WAIT);
    end
  vram_pipe u_pipe (
    .clk(CLK_25MHZ),
    .rst(RESET),
    .tag_in(issue_tag),
    .tag_out(ret_tag)
  );
  // RAM data arrives together with ret_tag; steer it by tag
  always_ff @(posedge CLK_25MHZ or posedge RESET)
    if (RESET) begin
      VID_VALID <= 1'b0;
      VID_DATA <= '0;
      CPU_ACK <= 1'b0;
      CPU_RDATA <= '0;
      CPU_ERR <= 1'b0;
    end else begin
      VID_VALID <= ret_tag.vid;
      VID_DATA <= ret_tag.vid ? MEM_RDATA : '0;
      CPU_ACK <= ret_tag.cpu;
      CPU_RDATA <= (ret_tag.cpu && !ret_tag.zero) ? MEM_RDATA : '0;
      CPU_ERR <= ret_tag.err;
    end
  assign MEM_ADDR = mem_q.addr;
  assign MEM_WE = mem_q.we;
  assign MEM_WDATA = mem_q.wdata;
endmodule
